instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// - Fetch stage directly upstream of the instruction decoder: holds the PC, issues word reads to instruction memory, buffers responses.
// - Presents {instr_out, instr_pc} to the IF/ID boundary with a valid/ready handshake; instr_out feeds the decoder's instr_in.
// - Accepts PC redirects from the execute stage (BEQ taken, jump) and squashes wrong-path fetches.
// PARAMETERS
// - PC_RESET    32'h0000_0000  PC value loaded on reset
// - FIFO_DEPTH  2              instruction buffer entries (power of 2, >=2)
// - CNT_W       2              width of occupancy/outstanding counters, must hold FIFO_DEPTH
// PORTS
// - clk             in   1   clock, all state updates on rising edge
// - rst_n           in   1   synchronous reset, active low
// - imem_req        out  1   read request valid
// - imem_addr       out  32  byte address of requested word (bits [1:0] always 2'b00)
// - imem_gnt        in   1   request accepted this cycle (req & gnt = issue)
// - imem_rvalid     in   1   read data valid, in-order, >=1 cycle after issue
// - imem_rdata      in   32  instruction word
// - redirect_valid  in   1   redirect fetch to redirect_pc, one-cycle pulse
// - redirect_pc     in   32  new fetch address (word aligned)
// - instr_valid     out  1   instr_out/instr_pc hold a valid instruction
// - instr_ready     in   1   decoder stage accepts (valid & ready = transfer)
// - instr_out       out  32  instruction word to decoder
// - instr_pc        out  32  byte address of instr_out
// BEHAVIOUR
// - Reset (rst_n=0 at edge): fetch_pc=PC_RESET, resp_pc=PC_RESET, FIFO empty, outstanding=0, drop_cnt=0, state=IDLE.
// - Reset outputs: imem_req=0, imem_addr=PC_RESET, instr_valid=0, instr_out=0, instr_pc=0.
// - Reset mid-operation discards everything. Any rvalid in the first cycle after reset is ignored (no request is outstanding).
// - FSM states:
//   - IDLE: one cycle after reset, no request; -> FETCH.
//   - FETCH: imem_req = (fifo_count + outstanding < FIFO_DEPTH); imem_addr = fetch_pc.
//   - DRAIN: imem_req=0; each rvalid decrements drop_cnt and its data is discarded; -> FETCH when drop_cnt reaches 0.
// - Issue (req & gnt): fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0); outstanding += 1.
// - Response (rvalid, not dropped): push {imem_rdata, resp_pc}; resp_pc += 4; outstanding -= 1. The credit rule guarantees the FIFO never overflows.
// - Issue and response in the same cycle leave outstanding unchanged.
// - Output: instr_valid = FIFO not empty; head entry drives instr_out and instr_pc. No combinational path from imem_rdata to instr_out.
// - Latency: response at edge N gives instr_valid=1 after edge N. FIFO full plus instr_ready=1 allows a push and a pop in the same cycle.
// - Redirect (redirect_valid at edge N):
//   - fetch_pc = resp_pc = redirect_pc; FIFO cleared.
//   - drop_cnt = outstanding after this cycle's issue, counting an rvalid arriving in cycle N as dropped.
//   - Next state: DRAIN if drop_cnt != 0, else FETCH.
//   - A valid&ready transfer in cycle N still completes; squashing it is downstream's job.
//   - No imem issue in cycle N: imem_req is forced to 0.
//   - A redirect during DRAIN reloads the PCs and keeps counting all still-outstanding responses.
// - Width rules: counters saturate never by construction. Assert outstanding <= FIFO_DEPTH and fifo_count <= FIFO_DEPTH.
// CONFIGURATION
// - JUMP_PREDECODE_EN defined:
//   - A pushed word with opcode [31:26]=6'b000101 (J-type) triggers an internal redirect to {resp_pc_plus4[31:28], imem_rdata[25:0], 2'b00}.
//   - The redirect takes effect at the next edge with the same squash rules as an external one, except the J word itself stays in the FIFO.
//   - An external redirect_valid in the same cycle wins and the J target is ignored.
// - JUMP_PREDECODE_EN undefined: J words pass through unchanged; only redirect_valid changes the fetch flow.
// STRUCTURE
// - Shared package/header (isa_defs):
//   - opcode localparams (R_type 000000 ... J_type 000101, Beq 000110, Load 000111, Store 001000);
//   - IF_IDLE/IF_FETCH/IF_DRAIN state encodings;
//   - PC_INCR=4.
// - Sub-module fetch_fifo: synchronous FIFO_DEPTH x 64-bit {pc,instr} with push, pop, flush, count, full, empty.
// - The FSM, PC logic and credit logic stay in instr_fetch_unit.
// TESTING
// 1. Reset release, gnt=1, 1-cycle rvalid, ready=1: imem_addr 0,4,8,...; instr_pc 0,4,8 back to back, one instruction per cycle.
// 2. instr_ready=0 for 10 cycles: at most FIFO_DEPTH issues, then imem_req=0. Release gives in-order drain with no loss or duplicate.
// 3. Redirect to 32'h100 with 2 outstanding, memory latency 3: the 2 stale rvalids are dropped, next instr_pc=32'h100.
// 4. Redirect in the same cycle as rvalid and instr_valid&ready: the transfer completes, the rvalid is dropped, the FIFO is empty next cycle.
// 5. JUMP_PREDECODE_EN, word 32'h1400_0040 fetched at pc 32'h8: the J word is delivered, the following instr_pc=32'h100, the pc 32'hC word is squashed.
//    Without the macro, pc 32'hC follows.
// 6. Reset asserted mid-DRAIN with rvalid pulses: outputs return to reset values and fetch restarts at PC_RESET.

Source files
------------

// File: rtl/isa_defs_pkg.sv
// Shared ISA definitions for the front end: opcodes, fetch-stage states, fetch buffer entry layout.
// JUMP_PREDECODE_EN (see instr_fetch_unit) uses the J-type helpers below.
package isa_defs_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_R_TYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_J_TYPE = 6'b000101;
  localparam logic [OPC_W-1:0] OP_BEQ    = 6'b000110;
  localparam logic [OPC_W-1:0] OP_LOAD   = 6'b000111;
  localparam logic [OPC_W-1:0] OP_STORE  = 6'b001000;

  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'b00,
    IF_FETCH = 2'b01,
    IF_DRAIN = 2'b10
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_j_type(input logic [OPC_W-1:0] opcode);
    return opcode == OP_J_TYPE;
  endfunction

  // Pseudo-direct jump target: upper nibble of pc+4, word index from the instruction.
  function automatic logic [XLEN-1:0] j_target(input logic [3:0] pc_hi, input logic [25:0] index);
    return {pc_hi, index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of {pc, instr} entries with push, pop and flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import isa_defs_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, credit-limited imem reads, response buffer, redirect squash of wrong-path reads.
// Optional JUMP_PREDECODE_EN: J-type words redirect fetch as soon as they are buffered.
module instr_fetch_unit
  import isa_defs_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);

  localparam int unsigned SUM_W = CNT_W + 1;

  if_state_e        state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [31:0]      resp_pc_inc;
  logic [31:0]      redir_target;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic             credit_ok;
  logic             rsp;
  logic             rsp_keep;
  logic             jump_hit;
  logic             redirect_any;
  logic             issue;
  logic             pop;

  // Reads in flight plus buffered words never exceed the buffer size.
  assign credit_ok   = (SUM_W'(fifo_count) + SUM_W'(outstanding_q)) < SUM_W'(FIFO_DEPTH);
  assign rsp         = imem_rvalid && (outstanding_q != '0);
  assign rsp_keep    = rsp && (state_q == IF_FETCH) && !redirect_valid;
  assign resp_pc_inc = resp_pc_q + PC_INCR;

`ifdef JUMP_PREDECODE_EN
  assign jump_hit     = rsp_keep && is_j_type(imem_rdata[31:26]);
  assign redir_target = redirect_valid ? redirect_pc
                                       : j_target(resp_pc_inc[31:28], imem_rdata[25:0]);
`else
  assign jump_hit     = 1'b0;
  assign redir_target = redirect_pc;
`endif

  assign redirect_any = redirect_valid || jump_hit;
  assign imem_req     = (state_q == IF_FETCH) && credit_ok && !redirect_any;
  assign imem_addr    = fetch_pc_q;
  assign issue        = imem_req && imem_gnt;
  assign pop          = instr_valid && instr_ready;
  assign push_entry   = '{pc: resp_pc_q, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IF_IDLE;
      fetch_pc_q    <= PC_RESET;
      resp_pc_q     <= PC_RESET;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rsp);

    if (issue)    fetch_pc_d = fetch_pc_q + PC_INCR;
    if (rsp_keep) resp_pc_d  = resp_pc_inc;

    case (state_q)
      IF_IDLE:  state_d = IF_FETCH;
      IF_FETCH: state_d = IF_FETCH;
      IF_DRAIN: begin
        if (rsp) begin
          drop_cnt_d = drop_cnt_q - CNT_W'(1);
          if (drop_cnt_q == CNT_W'(1)) state_d = IF_FETCH;
        end
      end
      default:  state_d = IF_IDLE;
    endcase

    // Every read still in flight after this cycle belongs to the old path.
    if (redirect_any) begin
      fetch_pc_d = redir_target;
      resp_pc_d  = redir_target;
      drop_cnt_d = outstanding_d;
      state_d    = (outstanding_d != '0) ? IF_DRAIN : IF_FETCH;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr_out   = fifo_empty ? '0 : fifo_head.instr;
  assign instr_pc    = fifo_empty ? '0 : fifo_head.pc;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (outstanding_q <= CNT_W'(FIFO_DEPTH));
      assert (fifo_count <= CNT_W'(FIFO_DEPTH));
      assert (!(rsp_keep && fifo_full && !pop));
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model plus a program-order stream model of delivered words.
// Honours JUMP_PREDECODE_EN when the design is built with it.
module tb_instr_fetch_unit;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam int          DEPTH    = 2;
`ifdef JUMP_PREDECODE_EN
  localparam logic [31:0] T5_NEXT  = 32'h0000_0100;
`else
  localparam logic [31:0] T5_NEXT  = 32'h0000_000C;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .PC_RESET   (PC_RESET),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          last_due = 0;
  int          lat = 1;
  bit          lat_rand = 0;
  bit          plant_j = 0;
  bit          chk_fetch = 1;
  bit          junk_rv = 0;
  bit          auto_redir = 0;
  bit          redir_fired = 0;
  logic [31:0] auto_redir_pc;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  int          n_xfer = 0;
  int          n_issue = 0;
  logic [31:0] last_xfer_pc;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_ins;

  // Memory image: each address gets a distinct non-jump word unless the J word is planted at 0x8.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (plant_j && a == 32'h8) return 32'h1400_0040;
    return {6'b000111, a[27:2] ^ 26'h15A_C3E5};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive memory response, sample outputs, advance the models.
  task automatic cycle();
    bit          from_q;
    int          due;
    logic [31:0] w;
    logic [31:0] nxt;
    from_q = 0;
    if (junk_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(q_addr[0]);
      from_q      = 1;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    if (auto_redir && instr_valid && instr_ready && imem_rvalid) begin
      redirect_valid = 1'b1;
      redirect_pc    = auto_redir_pc;
      auto_redir     = 0;
      redir_fired    = 1;
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_pc    = instr_pc;
    s_ins   = instr_out;
    if (s_valid && instr_ready) begin
      w = mem_word(exp_pc);
      chk("xfer_pc", s_pc, exp_pc);
      chk("xfer_instr", s_ins, w);
      n_xfer++;
      last_xfer_pc = s_pc;
      nxt = exp_pc + 32'd4;
`ifdef JUMP_PREDECODE_EN
      if (w[31:26] == 6'b000101) nxt = {nxt[31:28], w[25:0], 2'b00};
`endif
      exp_pc = nxt;
    end
    if (from_q) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    if (redirect_valid) chk("req_on_redirect", {31'b0, s_req}, 32'd0);
    if (s_req && imem_gnt) begin
      if (chk_fetch) chk("issue_addr", s_addr, exp_fetch);
      chk("addr_align", {30'b0, s_addr[1:0]}, 32'd0);
      exp_fetch = exp_fetch + 32'd4;
      n_issue++;
      due = cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      q_addr.push_back(s_addr);
      q_due.push_back(due);
    end
    if (redirect_valid) begin
      exp_pc    = redirect_pc;
      exp_fetch = redirect_pc;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    junk_rv        = 0;
    auto_redir     = 0;
    for (int i = 0; i < n; i++) begin
      imem_rvalid = (i % 2 == 0);
      imem_rdata  = $urandom;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    imem_rvalid = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, PC_RESET);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    q_addr.delete();
    q_due.delete();
    last_due  = cyc;
    exp_pc    = PC_RESET;
    exp_fetch = PC_RESET;
    rst_n     = 1'b1;
  endtask

  task automatic run_until_xfers(input int target, input string tag);
    int i;
    i = 0;
    while (n_xfer < target && i < 200) begin
      cycle();
      i++;
    end
    chk(tag, {31'b0, n_xfer >= target}, 32'd1);
  endtask

  initial begin
    int  n0;
    int  nb;
    int  i;
    logic ok;
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    // 1: streaming from reset with single-cycle memory
    do_reset(2);
    imem_gnt = 1'b1; instr_ready = 1'b1; lat = 1;
    cycle();
    chk("t1_idle_req", {31'b0, s_req}, 32'd0);
    cycle();
    chk("t1_first_req", {31'b0, s_req}, 32'd1);
    chk("t1_first_addr", s_addr, 32'h0);
    run_until_xfers(6, "t1_progress");
    chk("t1_sixth_pc", last_xfer_pc, 32'h14);

    // 2: decoder stall, credit limits issues, then drain
    instr_ready = 1'b0;
    n0 = n_issue;
    for (int k = 0; k < 10; k++) cycle();
    ok = (n_issue - n0) <= DEPTH;
    chk("t2_issue_bound", {31'b0, ok}, 32'd1);
    chk("t2_req_off", {31'b0, s_req}, 32'd0);
    chk("t2_valid_held", {31'b0, s_valid}, 32'd1);
    instr_ready = 1'b1;
    run_until_xfers(n_xfer + 6, "t2_drain");

    // 3: redirect with two reads outstanding, latency 3
    do_reset(2);
    lat = 3;
    n0 = n_issue; i = 0;
    while (n_issue < n0 + 2 && i < 10) begin cycle(); i++; end
    chk("t3_two_out", n_issue - n0, 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    i = 0;
    do begin cycle(); i++; end while (!s_valid && i < 30);
    chk("t3_valid", {31'b0, s_valid}, 32'd1);
    chk("t3_first_pc", s_pc, 32'h100);
    run_until_xfers(n_xfer + 3, "t3_more");

    // 4: redirect coinciding with a response and a transfer
    do_reset(2);
    lat = 1;
    auto_redir = 1; auto_redir_pc = 32'h200; redir_fired = 0;
    i = 0; nb = n_xfer;
    while (!redir_fired && i < 20) begin nb = n_xfer; cycle(); i++; end
    chk("t4_fired", {31'b0, redir_fired}, 32'd1);
    chk("t4_xfer_done", n_xfer, nb + 1);
    chk("t4_req_off", {31'b0, s_req}, 32'd0);
    cycle();
    chk("t4_fifo_empty", {31'b0, s_valid}, 32'd0);
    run_until_xfers(n_xfer + 3, "t4_more");

    // 5: J-type word at 0x8
    plant_j = 1; chk_fetch = 0;
    do_reset(2);
    i = 0;
    while (!(n_xfer > 0 && last_xfer_pc == 32'h8) && i < 40) begin cycle(); i++; end
    chk("t5_j_delivered", last_xfer_pc, 32'h8);
    run_until_xfers(n_xfer + 1, "t5_next_seen");
    chk("t5_after_j", last_xfer_pc, T5_NEXT);
    run_until_xfers(n_xfer + 3, "t5_more");

    // 6: reset in the middle of a drain, stray rvalid right after reset
    plant_j = 0;
    do_reset(2);
    chk_fetch = 1;
    lat = 3;
    n0 = n_issue; i = 0;
    while (n_issue < n0 + 2 && i < 10) begin cycle(); i++; end
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    cycle();
    cycle();
    do_reset(3);
    junk_rv = 1;
    cycle();
    junk_rv = 0;
    chk("t6_idle_req", {31'b0, s_req}, 32'd0);
    i = 0;
    do begin cycle(); i++; end while (!s_valid && i < 30);
    chk("t6_valid", {31'b0, s_valid}, 32'd1);
    chk("t6_restart_pc", s_pc, PC_RESET);

    // Random traffic: grant/ready jitter, variable latency, redirects including near the wrap point
    do_reset(2);
    lat_rand = 1;
    n0 = n_xfer;
    for (int k = 0; k < 2000; k++) begin
      imem_gnt    = ($urandom_range(0, 99) < 75);
      instr_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      end
      cycle();
    end
    imem_gnt = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    ok = (n_xfer - n0) > 100;
    chk("rand_progress", {31'b0, ok}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
